// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer, synchronous flush and a
// saturating bubble counter. in_ready is registered so decode stalls never reach fetch combinationally.
module ifid_skid_reg #(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h4400_0000,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic               r_out_valid, w_out_valid_d;
  logic [PC_W-1:0]    r_out_pc, w_out_pc_d;
  logic [INSTR_W-1:0] r_out_instr, w_out_instr_d;
  logic               r_skid_valid, w_skid_valid_d;
  logic [PC_W-1:0]    r_skid_pc, w_skid_pc_d;
  logic [INSTR_W-1:0] r_skid_instr, w_skid_instr_d;
  logic [CNT_W-1:0]   r_bubble_cnt, w_bubble_cnt_d;
  logic               w_accept;
  logic               w_drain;

  assign w_accept = in_valid & ~r_skid_valid;
  assign w_drain  = r_out_valid & out_ready;

  always_comb begin
    w_out_valid_d  = r_out_valid;
    w_out_pc_d     = r_out_pc;
    w_out_instr_d  = r_out_instr;
    w_skid_valid_d = r_skid_valid;
    w_skid_pc_d    = r_skid_pc;
    w_skid_instr_d = r_skid_instr;
    if (flush) begin
      w_out_valid_d  = 1'b0;
      w_out_pc_d     = '0;
      w_out_instr_d  = NOP_INSTR;
      w_skid_valid_d = 1'b0;
    end else if (!r_out_valid || w_drain) begin
      if (r_skid_valid) begin
        w_out_valid_d  = 1'b1;
        w_out_pc_d     = r_skid_pc;
        w_out_instr_d  = r_skid_instr;
        w_skid_valid_d = 1'b0;
      end else if (w_accept) begin
        w_out_valid_d = 1'b1;
        w_out_pc_d    = in_pc;
        w_out_instr_d = in_instr;
      end else begin
        // Empty slot always shows a NOP so decode may ignore out_valid.
        w_out_valid_d = 1'b0;
        w_out_pc_d    = '0;
        w_out_instr_d = NOP_INSTR;
      end
    end else if (w_accept) begin
      w_skid_valid_d = 1'b1;
      w_skid_pc_d    = in_pc;
      w_skid_instr_d = in_instr;
    end
  end

  always_comb begin
    w_bubble_cnt_d = r_bubble_cnt;
    if (!r_out_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      w_bubble_cnt_d = r_bubble_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_pc     <= '0;
      r_out_instr  <= NOP_INSTR;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_out_valid  <= w_out_valid_d;
      r_out_pc     <= w_out_pc_d;
      r_out_instr  <= w_out_instr_d;
      r_skid_valid <= w_skid_valid_d;
      r_skid_pc    <= w_skid_pc_d;
      r_skid_instr <= w_skid_instr_d;
      r_bubble_cnt <= w_bubble_cnt_d;
    end
  end

  assign in_ready   = ~r_skid_valid;
  assign out_valid  = r_out_valid;
  assign out_pc     = r_out_pc;
  assign out_instr  = r_out_instr;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: the register pair is modelled as a two-deep FIFO queue;
// a second instance with CNT_W=2 exercises bubble-counter saturation.
module tb_ifid_skid_reg;

  localparam logic [31:0] Nop = 32'h4400_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  logic [15:0] bubble_cnt;
  logic        in_ready2, out_valid2;
  logic [31:0] out_pc2, out_instr2;
  logic [1:0]  bubble_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ifid_skid_reg u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_ready(out_ready), .bubble_cnt(bubble_cnt)
  );

  ifid_skid_reg #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_ready(in_ready2), .out_valid(out_valid2), .out_pc(out_pc2),
    .out_instr(out_instr2), .out_ready(out_ready), .bubble_cnt(bubble_cnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: up to two words in flight, front of queue is what decode sees.
  logic [63:0] q[$];
  int          bub = 0;
  int          bub2 = 0;
  logic        last_acc = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      bub = 0;
      bub2 = 0;
      last_acc = 1'b0;
    end else begin
      logic acc, drn;
      if (q.size() == 0) begin
        if (bub < 65535) bub++;
        if (bub2 < 3) bub2++;
      end
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      last_acc = acc;
      if (flush) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back({in_pc, in_instr});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic        ev;
      logic [31:0] epc, ein;
      ev  = q.size() > 0;
      epc = ev ? q[0][63:32] : 32'h0;
      ein = ev ? q[0][31:0] : Nop;
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out_pc", 64'(out_pc), 64'(epc));
      chk("out_instr", 64'(out_instr), 64'(ein));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(bub));
      chk("out_pc2", 64'(out_pc2), 64'(epc));
      chk("in_ready2", 64'(in_ready2), 64'(q.size() < 2));
      chk("bubble_cnt2", 64'(bubble_cnt2), 64'(bub2));
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("lit_idle_valid", 64'(out_valid), 64'd0);
    chk("lit_idle_instr", 64'(out_instr), 64'h4400_0000);
    chk("lit_idle_pc", 64'(out_pc), 64'd0);
    chk("lit_idle_ready", 64'(in_ready), 64'd1);
    chk("lit_idle_bub", 64'(bubble_cnt), 64'd3);
    repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("lit_sat_bub2", 64'(bubble_cnt2), 64'd3);
    chk("lit_bub6", 64'(bubble_cnt), 64'd6);

    // Back-to-back stream
    drive(1'b1, 32'h0, 32'h2008_0001, 1'b1, 1'b0);
    chk("lit_s0_pc", 64'(out_pc), 64'h0);
    chk("lit_s0_instr", 64'(out_instr), 64'h2008_0001);
    drive(1'b1, 32'h4, 32'h2009_0002, 1'b1, 1'b0);
    chk("lit_s1_instr", 64'(out_instr), 64'h2009_0002);
    chk("lit_s1_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h8, 32'h012A_5020, 1'b1, 1'b0);
    chk("lit_s2_pc", 64'(out_pc), 64'h8);
    chk("lit_s2_valid", 64'(out_valid), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Stall: 0x4 lands in skid, 0x8 held by source
    drive(1'b1, 32'h0, 32'h2008_0001, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 32'h2009_0002, 1'b0, 1'b0);
    chk("lit_st_ready", 64'(in_ready), 64'd0);
    chk("lit_st_pc", 64'(out_pc), 64'h0);
    drive(1'b1, 32'h8, 32'h012A_5020, 1'b0, 1'b0);
    chk("lit_st_hold", 64'(out_pc), 64'h0);
    drive(1'b1, 32'h8, 32'h012A_5020, 1'b1, 1'b0);
    chk("lit_st_pc4", 64'(out_pc), 64'h4);
    drive(1'b1, 32'h8, 32'h012A_5020, 1'b1, 1'b0);
    chk("lit_st_pc8", 64'(out_pc), 64'h8);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("lit_st_empty", 64'(out_valid), 64'd0);

    // Flush with skid full
    drive(1'b1, 32'h10, 32'h1111_0000, 1'b0, 1'b0);
    drive(1'b1, 32'h14, 32'h1414_0000, 1'b0, 1'b0);
    drive(1'b1, 32'h18, 32'h1818_0000, 1'b0, 1'b1);
    chk("lit_fl_valid", 64'(out_valid), 64'd0);
    chk("lit_fl_instr", 64'(out_instr), 64'h4400_0000);
    chk("lit_fl_ready", 64'(in_ready), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("lit_fl_gone", 64'(out_valid), 64'd0);

    // Randomized traffic; source holds a word until it is accepted
    begin
      logic [31:0] pc;
      pc = 32'h100;
      in_valid = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        logic v;
        if (!in_valid || last_acc) begin
          v = ($urandom_range(0, 3) != 0);
          if (v) begin
            in_pc = pc;
            in_instr = $urandom;
            pc = pc + 32'h4;
          end
          in_valid = v;
        end
        out_ready = ($urandom_range(0, 2) != 0);
        flush = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
    end

    // Async reset mid-stall, checked before any clock edge
    drive(1'b1, 32'h40, 32'h4040_0000, 1'b0, 1'b0);
    drive(1'b1, 32'h44, 32'h4444_0000, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("lit_rst_valid", 64'(out_valid), 64'd0);
    chk("lit_rst_pc", 64'(out_pc), 64'd0);
    chk("lit_rst_instr", 64'(out_instr), 64'h4400_0000);
    chk("lit_rst_ready", 64'(in_ready), 64'd1);
    chk("lit_rst_bub", 64'(bubble_cnt), 64'd0);
    chk("lit_rst_bub2", 64'(bubble_cnt2), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
